// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the five-stage CPU.
// It drives the stall (hold) and flush (clear) controls of the F/D, D/E,
// E/M and M/W pipeline registers. It handles, from highest to lowest
// priority: data-memory wait states, multi-cycle execute ops, taken
// branches and load-use hazards. It also keeps a saturating count of
// stall cycles.
//
// Ports:
//   clk, reset            clock; synchronous active-low reset
//   rs1_d, rs2_d          source registers of the instruction in D
//   rd_e, memtoreg_e      destination register / load flag of the instruction in E
//   pcsrc_e               a taken branch or jump is in E
//   mc_start_e            a multi-cycle op is in E (held high while it stays there)
//   mem_req_m, mem_ready  data-memory access in M, and its completion
//   stall_*, flush_*      per-stage hold / clear controls (combinational)
//   mc_busy               a multi-cycle op is being tracked
//   stall_count           number of stall_f cycles since reset, saturating
module hazard_ctrl #(
    parameter int REG_ADDR_W = 4,
    parameter int MC_CYCLES  = 4,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] rs1_d,
    input  logic [REG_ADDR_W-1:0] rs2_d,
    input  logic [REG_ADDR_W-1:0] rd_e,
    input  logic                  memtoreg_e,
    input  logic                  pcsrc_e,
    input  logic                  mc_start_e,
    input  logic                  mem_req_m,
    input  logic                  mem_ready,
    output logic                  stall_f,
    output logic                  stall_d,
    output logic                  stall_e,
    output logic                  stall_m,
    output logic                  flush_d,
    output logic                  flush_e,
    output logic                  flush_m,
    output logic                  flush_w,
    output logic                  mc_busy,
    output logic [CNT_W-1:0]      stall_count
);

    localparam int CW = (MC_CYCLES > 2) ? $clog2(MC_CYCLES) : 1;

    typedef enum logic {
        IDLE    = 1'b0,
        MC_BUSY = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;

    logic memstall, lwstall, mcstall, idle;

    always_comb begin
        idle     = (state_q == IDLE);
        memstall = mem_req_m & ~mem_ready;
        lwstall  = memtoreg_e & (rd_e != '0) & ((rd_e == rs1_d) | (rd_e == rs2_d));
        mcstall  = (idle & mc_start_e) | (~idle & (cnt_q != '0));
    end

    always_comb begin
        stall_f       = 1'b0;
        stall_d       = 1'b0;
        stall_e       = 1'b0;
        stall_m       = 1'b0;
        flush_d       = 1'b0;
        flush_e       = 1'b0;
        flush_m       = 1'b0;
        flush_w       = 1'b0;
        state_d       = state_q;
        cnt_d         = cnt_q;
        stall_count_d = stall_count_q;

        if (!reset) begin
            // Outputs stay low while reset is held; any op in flight is dropped.
            state_d       = IDLE;
            cnt_d         = '0;
            stall_count_d = '0;
        end else begin
            if (memstall) begin
                // Whole pipe holds; FSM and counter are frozen.
                stall_f = 1'b1;
                stall_d = 1'b1;
                stall_e = 1'b1;
                stall_m = 1'b1;
                flush_w = 1'b1;
            end else if (mcstall) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                stall_e = 1'b1;
                flush_m = 1'b1;
                if (idle) begin
                    state_d = MC_BUSY;
                    cnt_d   = CW'(MC_CYCLES - 2);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end else if (!idle) begin
                // Final cycle of the op: no stall, so it leaves E at this edge.
                state_d = IDLE;
            end else if (pcsrc_e) begin
                flush_d = 1'b1;
                flush_e = 1'b1;
            end else if (lwstall) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                flush_e = 1'b1;
            end

            if (stall_f && (stall_count_q != '1)) begin
                stall_count_d = stall_count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        state_q       <= state_d;
        cnt_q         <= cnt_d;
        stall_count_q <= stall_count_d;
    end

    assign mc_busy     = reset & (state_q == MC_BUSY);
    assign stall_count = reset ? stall_count_q : '0;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl with an op-age reference model checked
// every cycle, plus literal expectations at key points of each scenario.
module tb_hazard_ctrl;

    localparam int RW  = 4;
    localparam int MC  = 4;
    localparam int CW  = 4;
    localparam int MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [RW-1:0] rs1_d, rs2_d, rd_e;
    logic          memtoreg_e, pcsrc_e, mc_start_e, mem_req_m, mem_ready;
    logic          stall_f, stall_d, stall_e, stall_m;
    logic          flush_d, flush_e, flush_m, flush_w, mc_busy;
    logic [CW-1:0] stall_count;

    int tests  = 0;
    int failed = 0;

    hazard_ctrl #(.REG_ADDR_W(RW), .MC_CYCLES(MC), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_e(rd_e),
        .memtoreg_e(memtoreg_e), .pcsrc_e(pcsrc_e), .mc_start_e(mc_start_e),
        .mem_req_m(mem_req_m), .mem_ready(mem_ready),
        .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
        .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m), .flush_w(flush_w),
        .mc_busy(mc_busy), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    // Packed view: {sf, sd, se, sm, fd, fe, fm, fw, busy}
    logic [8:0] outv;
    assign outv = {stall_f, stall_d, stall_e, stall_m,
                   flush_d, flush_e, flush_m, flush_w, mc_busy};

    // Reference model: an op is tracked by how many non-wait cycles it has
    // spent in E. It stalls while its age is below MC-1 and leaves after the
    // cycle at age MC-1.
    bit in_op   = 1'b0;
    int age     = 0;
    int m_count = 0;
    bit chk_en  = 1'b0;

    function automatic logic [8:0] model_out();
        logic [8:0] v;
        bit mem, lw, mcs;
        v = '0;
        if (!reset) return v;
        mem = mem_req_m && !mem_ready;
        lw  = memtoreg_e && (rd_e != 0) && (rd_e == rs1_d || rd_e == rs2_d);
        mcs = in_op ? (age < MC - 1) : mc_start_e;
        if (mem)                  v = 9'b1111_0001_0;
        else if (mcs)             v = 9'b1110_0010_0;
        else if (!in_op && pcsrc_e) v = 9'b0000_1100_0;
        else if (!in_op && lw)    v = 9'b1100_0100_0;
        v[0] = in_op;
        return v;
    endfunction

    always @(posedge clk) begin
        logic [8:0] e;
        e = model_out();
        if (!reset) begin
            in_op = 1'b0; age = 0; m_count = 0; chk_en = 1'b1;
        end else begin
            if (e[8] && m_count < MAX) m_count = m_count + 1;
            if (!(mem_req_m && !mem_ready)) begin
                if (!in_op && mc_start_e) begin
                    in_op = 1'b1; age = 1;
                end else if (in_op) begin
                    if (age == MC - 1) begin in_op = 1'b0; age = 0; end
                    else age = age + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [8:0] e;
        int ec;
        if (chk_en) begin
            e  = model_out();
            ec = reset ? m_count : 0;
            tests++;
            if (outv !== e) begin
                failed++;
                $display("FAIL model_outputs t=%0t: got %b expected %b", $time, outv, e);
            end
            tests++;
            if (stall_count !== CW'(ec)) begin
                failed++;
                $display("FAIL model_count t=%0t: got %0d expected %0d", $time, stall_count, ec);
            end
        end
    end

    task automatic apply(input logic rst, input logic [RW-1:0] r1, r2, rde,
                         input logic mte, pcs, mcs, mrq, mrd);
        @(posedge clk); #1;
        reset = rst; rs1_d = r1; rs2_d = r2; rd_e = rde;
        memtoreg_e = mte; pcsrc_e = pcs; mc_start_e = mcs;
        mem_req_m = mrq; mem_ready = mrd;
    endtask

    task automatic lit(input string nm, input logic [8:0] exp);
        @(negedge clk);
        tests++;
        if (outv !== exp) begin
            failed++;
            $display("FAIL %s: got %b expected %b", nm, outv, exp);
        end
    endtask

    task automatic lit_cnt(input string nm, input int exp);
        tests++;
        if (stall_count !== CW'(exp)) begin
            failed++;
            $display("FAIL %s: got count %0d expected %0d", nm, stall_count, exp);
        end
    endtask

    task automatic do_reset();
        apply(0, 0, 0, 0, 0, 0, 0, 0, 1);
        lit("reset_outputs", 9'b0);
        lit_cnt("reset_count", 0);
    endtask

    initial begin
        reset = 1'b0; rs1_d = '0; rs2_d = '0; rd_e = '0;
        memtoreg_e = 1'b0; pcsrc_e = 1'b0; mc_start_e = 1'b0;
        mem_req_m = 1'b0; mem_ready = 1'b1;
        do_reset();
        apply(1, 0, 0, 0, 0, 0, 0, 0, 1); lit("idle", 9'b0);

        // Load-use hazard on rs2, then rs1, then rd=0 and no match
        apply(1, 1, 5, 5, 1, 0, 0, 0, 1); lit("loaduse_rs2", 9'b1100_0100_0);
        apply(1, 7, 2, 7, 1, 0, 0, 0, 1); lit("loaduse_rs1", 9'b1100_0100_0);
        apply(1, 0, 0, 0, 1, 0, 0, 0, 1); lit("loaduse_r0", 9'b0);
        apply(1, 3, 4, 6, 1, 0, 0, 0, 1); lit("load_nomatch", 9'b0);
        apply(1, 5, 5, 5, 0, 0, 0, 0, 1); lit("noload_match", 9'b0);
        apply(1, 0, 0, 0, 0, 0, 0, 0, 1); lit_cnt("count_after_lu", 2);

        // Taken branch, alone and together with load-use
        apply(1, 0, 0, 0, 0, 1, 0, 0, 1); lit("branch", 9'b0000_1100_0);
        apply(1, 5, 0, 5, 1, 1, 0, 0, 1); lit("branch_over_lu", 9'b0000_1100_0);

        // Multi-cycle op, no waits
        do_reset();
        apply(1, 0, 0, 0, 0, 0, 1, 0, 1); lit("mc_c1", 9'b1110_0010_0);
        apply(1, 5, 0, 5, 1, 1, 1, 0, 1); lit("mc_c2", 9'b1110_0010_1);
        apply(1, 0, 0, 0, 0, 0, 1, 0, 1); lit("mc_c3", 9'b1110_0010_1);
        apply(1, 5, 0, 5, 1, 1, 1, 0, 1); lit("mc_c4", 9'b0000_0000_1);
        lit_cnt("mc_count", 3);
        apply(1, 0, 0, 0, 0, 0, 0, 0, 1); lit("mc_done", 9'b0);

        // Memory wait in the middle of a multi-cycle op
        do_reset();
        apply(1, 0, 0, 0, 0, 0, 1, 0, 1); lit("mw_c1", 9'b1110_0010_0);
        apply(1, 0, 0, 0, 0, 0, 1, 0, 1); lit("mw_c2", 9'b1110_0010_1);
        apply(1, 0, 0, 0, 0, 0, 1, 1, 0); lit("mw_c3", 9'b1111_0001_1);
        apply(1, 0, 0, 0, 0, 0, 1, 1, 0); lit("mw_c4", 9'b1111_0001_1);
        apply(1, 0, 0, 0, 0, 0, 1, 1, 1); lit("mw_c5", 9'b1110_0010_1);
        apply(1, 0, 0, 0, 0, 0, 1, 0, 1); lit("mw_c6", 9'b0000_0000_1);
        lit_cnt("mw_count", 5);
        apply(1, 0, 0, 0, 0, 0, 0, 0, 1); lit("mw_done", 9'b0);

        // Reset while busy with cnt=1
        do_reset();
        apply(1, 0, 0, 0, 0, 0, 1, 0, 1); lit("rm_c1", 9'b1110_0010_0);
        apply(1, 0, 0, 0, 0, 0, 1, 0, 1); lit("rm_c2", 9'b1110_0010_1);
        apply(0, 5, 0, 5, 1, 1, 1, 1, 0); lit("rm_in_reset", 9'b0);
        lit_cnt("rm_count_in_reset", 0);
        apply(1, 0, 0, 0, 0, 0, 0, 0, 1); lit("rm_after", 9'b0);
        lit_cnt("rm_count_after", 0);

        // Counter saturation under a long memory wait
        do_reset();
        for (int i = 0; i < 20; i++) begin
            apply(1, 0, 0, 0, 0, 0, 0, 1, 0);
        end
        apply(1, 0, 0, 0, 0, 0, 0, 0, 1); lit("sat_release", 9'b0);
        lit_cnt("sat_count", 15);
        apply(1, 0, 0, 0, 0, 0, 0, 0, 1); lit("sat_hold", 9'b0);
        lit_cnt("sat_count_hold", 15);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage CPU. It generates the per-stage stall (hold) and flush (clear) controls that drive the clear-capable pipeline registers between F/D, D/E, E/M and M/W. It resolves four hazard classes:
- load-use data hazards
- taken branches
- multi-cycle execute operations (vector unit), tracked by an internal FSM and counter
- data-memory wait states

It also keeps a saturating stall-cycle performance counter.

## Interface
Parameters:
- REG_ADDR_W, 4, register-address width
- MC_CYCLES, 4, total cycles a multi-cycle op occupies E; legal range ≥ 2
- CNT_W, 16, width of the stall performance counter

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-low reset; sampled on rising edge of clk
- rs1_d, rs2_d  in  REG_ADDR_W  source registers of the instruction in D
- rd_e  in  REG_ADDR_W  destination register of the instruction in E
- memtoreg_e  in  1  instruction in E is a load
- pcsrc_e  in  1  branch/jump in E is taken
- mc_start_e  in  1  instruction in E is a multi-cycle op; held high while it sits in E
- mem_req_m  in  1  instruction in M accesses data memory
- mem_ready  in  1  data memory completes the access this cycle
- stall_f, stall_d, stall_e, stall_m  out  1  hold PC / F-D / D-E / E-M register
- flush_d, flush_e, flush_m, flush_w  out  1  clear F-D / D-E / E-M / M-W register next edge
- mc_busy  out  1  FSM in MC_BUSY
- stall_count  out  CNT_W  cycles with stall_f=1 since reset, saturating

## Operation
- State: FSM {IDLE, MC_BUSY}, down-counter cnt (ceil(log2 MC_CYCLES) bits), stall_count.
- Hazard conditions:
  - memstall = mem_req_m & ~mem_ready
  - lwstall = memtoreg_e & (rd_e ≠ 0) & ((rd_e == rs1_d) | (rd_e == rs2_d)); register 0 never causes a stall.
  - mcstall = (IDLE & mc_start_e) | (MC_BUSY & cnt ≠ 0)
- Output priority (highest first). Only the winning class drives outputs; all other outputs are 0.
  1. memstall: stall_f, stall_d, stall_e, stall_m = 1; flush_w = 1. The FSM, cnt and any pending branch or load-use action are frozen.
  2. mcstall: stall_f, stall_d, stall_e = 1; flush_m = 1 (bubble into M).
  3. pcsrc_e, IDLE only: flush_d = 1, flush_e = 1.
  4. lwstall, IDLE only: stall_f = 1, stall_d = 1, flush_e = 1.
- In MC_BUSY, pcsrc_e, memtoreg_e and lwstall are ignored, because E holds the multi-cycle op.
- FSM transitions (only when memstall = 0):
  - IDLE & mc_start_e → MC_BUSY, cnt ← MC_CYCLES−2
  - MC_BUSY & cnt ≠ 0 → cnt ← cnt−1
  - MC_BUSY & cnt = 0 → IDLE; no stall that cycle, so the op leaves E at the next edge. mc_start_e is ignored in that cycle.
- stall_count increments on each edge where stall_f = 1 and reset is high; it holds at 2^CNT_W−1.
- Reset (reset = 0 at an edge) → IDLE, cnt = 0, stall_count = 0. While reset is low, all outputs are 0, including combinational ones. A multi-cycle op in flight is abandoned.

## Timing
- All stall/flush outputs are combinational from the current inputs and registered state (zero latency). They are consumed at the same rising edge.
- A multi-cycle op raises stall_f for exactly MC_CYCLES−1 consecutive cycles when no memstall occurs. Each memstall cycle extends that window by one cycle.
- mc_busy is asserted the cycle after mc_start_e is first seen in IDLE, and stays high through the cnt = 0 cycle.
- Load-use costs one bubble. A taken branch costs two flushed slots. Memory wait costs one cycle per cycle that mem_ready is low.
- stall_count reflects a stall cycle from the edge after that cycle.

## Test plan
- Load-use: memtoreg_e=1, rd_e=5, rs2_d=5 → stall_f = stall_d = flush_e = 1 for one cycle; with rd_e=0 → all outputs 0.
- Taken branch: pcsrc_e=1 in IDLE → flush_d = flush_e = 1 and no stalls; with memtoreg_e also high, branch still wins.
- Multi-cycle op, MC_CYCLES=4: mc_start_e held 4 cycles → stall_f/d/e and flush_m high for cycles 1–3 and low in cycle 4; mc_busy high in cycles 2–4; stall_count = 3.
- Memory wait inside multi-cycle op: mem_req_m=1, mem_ready=0 for 2 cycles in mid-MC_BUSY → all four stalls plus flush_w; cnt frozen; total stall_f window = 5 cycles; stall_count = 5.
- Reset mid-op: reset=0 during MC_BUSY with cnt=1 → next cycle IDLE, mc_busy = 0, stall_count = 0, all outputs 0 while reset is low.
- Saturation, CNT_W=4: hold mem_req_m=1, mem_ready=0 for 20 cycles → stall_count stops at 15.
